// File: rtl/demux8_wr_bank_pkg.sv
// Shared sizing and index types for the eight-entry write-demux register bank
// and its 3-to-8 write decoder.
package demux8_wr_bank_pkg;

  localparam int unsigned NUM_ENTRIES = 8;
  localparam int unsigned SEL_W       = 3;

  typedef logic [NUM_ENTRIES-1:0] onehot_t;
  typedef logic [SEL_W-1:0]       sel_t;

endpackage

// File: rtl/demux8_wr_bank_decoder3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; reusable for any
// register-file write-enable fan-out.
module decoder3to8
  import demux8_wr_bank_pkg::*;
(
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_ENTRIES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux8_wr_bank.sv
// Eight-entry register bank: one-stage write commit register feeding a one-hot
// demux into the entry array, plus a registered read port with commit bypass.
module demux8_wr_bank
  import demux8_wr_bank_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          ZERO_E0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   wr_en,
  input  logic [SEL_W-1:0]       wr_sel,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [SEL_W-1:0]       rd_sel,
  output logic [WIDTH-1:0]       rd_data,
  output logic [NUM_ENTRIES-1:0] wr_onehot,
  output logic [NUM_ENTRIES-1:0] valid_map
);

  logic             pend;
  sel_t             cmt_sel;
  logic [WIDTH-1:0] cmt_data;
  onehot_t          dec_raw;
  onehot_t          dec;
  logic             bypass;
  logic [WIDTH-1:0] entries [NUM_ENTRIES];

  decoder3to8 u_dec (
    .en     (pend),
    .sel    (cmt_sel),
    .onehot (dec_raw)
  );

  always_comb begin
    dec = dec_raw;
    if (ZERO_E0) begin
      dec[0] = 1'b0;
    end
  end

  // Decoded purely from registered commit state, so it behaves as a registered output.
  assign wr_onehot = dec;

  // The commit register always holds the youngest write, so it overrides the array.
  assign bypass = pend && (cmt_sel == rd_sel) && !(ZERO_E0 && (cmt_sel == '0));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pend     <= 1'b0;
      cmt_sel  <= '0;
      cmt_data <= '0;
    end else begin
      pend <= wr_en;
      if (wr_en) begin
        cmt_sel  <= wr_sel;
        cmt_data <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= '0;
      end
      valid_map <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (dec[i]) begin
          entries[i]   <= cmt_data;
          valid_map[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_data <= '0;
    end else if (bypass) begin
      rd_data <= cmt_data;
    end else begin
      rd_data <= entries[rd_sel];
    end
  end

endmodule

// File: tb/tb_demux8_wr_bank.sv
// Directed + random bench for demux8_wr_bank against a value-visibility model
// of the bank (last-written value per index, commit one edge later).
module tb_demux8_wr_bank;

  localparam int unsigned W = 32;

  logic         clk;
  logic         arst;
  logic         wr_en;
  logic [2:0]   wr_sel;
  logic [W-1:0] wr_data;
  logic [2:0]   rd_sel;
  logic [W-1:0] rd_data;
  logic [7:0]   wr_onehot;
  logic [7:0]   valid_map;

  int checks   = 0;
  int failures = 0;

  // Reference state: the value a read must return, and the expected flags.
  logic [W-1:0] vis [8];
  logic [7:0]   valid_exp;
  logic [7:0]   prev_oh;
  logic [7:0]   oh_exp;
  logic [W-1:0] rd_exp;

  demux8_wr_bank #(.WIDTH(W), .ZERO_E0(1'b1)) dut (
    .clk       (clk),
    .arst      (arst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .wr_onehot (wr_onehot),
    .valid_map (valid_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) vis[i] = '0;
    valid_exp = '0;
    prev_oh   = '0;
    oh_exp    = '0;
    rd_exp    = '0;
  endtask

  // Called at posedge+1; drives inputs, advances one edge, then checks all outputs.
  task automatic cycle(input logic en, input logic [2:0] sel, input logic [W-1:0] data,
                       input logic [2:0] rsel);
    wr_en   = en;
    wr_sel  = sel;
    wr_data = data;
    rd_sel  = rsel;
    @(posedge clk);
    rd_exp    = (rsel == 3'd0) ? '0 : vis[rsel];
    valid_exp = valid_exp | prev_oh;
    oh_exp    = (en && sel != 3'd0) ? (8'b1 << sel) : 8'b0;
    if (en && sel != 3'd0) vis[sel] = data;
    prev_oh = oh_exp;
    #1;
    chk("rd_data", rd_data, rd_exp);
    chk("wr_onehot", {24'd0, wr_onehot}, {24'd0, oh_exp});
    chk("valid_map", {24'd0, valid_map}, {24'd0, valid_exp});
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_sel = '0;
  endtask

  initial begin
    idle_inputs();
    arst = 1'b1;
    model_reset();
    #3 arst = 1'b0;
    @(posedge clk); #1;

    // Populate state so the asynchronous reset has something to clear.
    cycle(1'b1, 3'd4, 32'hCAFE_0004, 3'd0);
    cycle(1'b1, 3'd6, 32'hCAFE_0006, 3'd4);
    cycle(1'b0, 3'd0, '0, 3'd6);

    // Mid-cycle asynchronous reset: outputs must clear before any edge.
    #3 arst = 1'b1;
    #1;
    chk("async_rst_rd", rd_data, '0);
    chk("async_rst_oh", {24'd0, wr_onehot}, '0);
    chk("async_rst_vm", {24'd0, valid_map}, '0);
    idle_inputs();
    model_reset();
    @(posedge clk); #2 arst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, '0, 3'(i));

    // Basic write then read.
    cycle(1'b1, 3'd5, 32'hDEAD_BEEF, 3'd0);
    chk("basic_onehot", {24'd0, wr_onehot}, 32'h0000_0020);
    cycle(1'b0, 3'd0, '0, 3'd0);
    cycle(1'b0, 3'd0, '0, 3'd5);
    chk("basic_rd", rd_data, 32'hDEAD_BEEF);
    chk("basic_valid5", {31'd0, valid_map[5]}, 32'd1);

    // Bypass: read the entry on the edge right after its capture.
    cycle(1'b1, 3'd3, 32'h1111_1111, 3'd0);
    cycle(1'b0, 3'd0, '0, 3'd0);
    cycle(1'b1, 3'd3, 32'h1234_5678, 3'd3);
    chk("pre_capture_old", rd_data, 32'h1111_1111);
    cycle(1'b0, 3'd0, '0, 3'd3);
    chk("bypass_rd", rd_data, 32'h1234_5678);

    // Hardwired-zero entry 0.
    cycle(1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0);
    chk("zero_onehot", {24'd0, wr_onehot}, '0);
    cycle(1'b0, 3'd0, '0, 3'd0);
    chk("zero_rd", rd_data, '0);
    chk("zero_valid0", {31'd0, valid_map[0]}, '0);

    // Back-to-back writes to the same index.
    cycle(1'b1, 3'd7, 32'hA, 3'd0);
    cycle(1'b1, 3'd7, 32'hB, 3'd7);
    cycle(1'b0, 3'd0, '0, 3'd7);
    chk("b2b_rd", rd_data, 32'hB);
    cycle(1'b0, 3'd0, '0, 3'd7);
    chk("b2b_rd_stored", rd_data, 32'hB);

    // Reset while a write is pending: it must be dropped.
    cycle(1'b1, 3'd2, 32'h55, 3'd0);
    idle_inputs();
    #3 arst = 1'b1;
    model_reset();
    @(posedge clk); #2 arst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0, 3'd0, '0, 3'd2);
    chk("rst_drop_rd", rd_data, '0);
    chk("rst_drop_valid2", {31'd0, valid_map[2]}, '0);

    // Randomized traffic, biased toward frequent writes and collisions.
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), W'($urandom),
            3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
